// File: rtl/rx_defs.sv
// rx_defs: sync-header constants, lock FSM states and header check shared by the RX path
package rx_defs;
   localparam logic [1:0] HDR_DATA = 2'b01;
   localparam logic [1:0] HDR_CTRL = 2'b10;
   typedef enum logic [1:0] {ST_HUNT, ST_WAIT, ST_LOCKED} state_t;
   function automatic logic is_good_hdr(input logic [1:0] hdr);
      return hdr == HDR_DATA || hdr == HDR_CTRL;
   endfunction
endpackage

// File: rtl/rx_sat_counter.sv
// rx_sat_counter: up-counter with synchronous clear that sticks at all-ones
module rx_sat_counter #(
   parameter int W = 16
) (
   input  logic         USER_CLK,
   input  logic         SYSTEM_RESET_N,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);
   always_ff @(posedge USER_CLK) begin
      if (!SYSTEM_RESET_N || clr) count <= '0;
      else if (inc && count != {W{1'b1}}) count <= count + 1'b1;
   end
endmodule

// File: rtl/rx_word_lock.sv
// rx_word_lock: sync-header word alignment with gearbox slip control and lock monitoring
module rx_word_lock
   import rx_defs::*;
#(
   parameter int LOCK_COUNT = 64,
   parameter int WINDOW     = 64,
   parameter int ERR_LIMIT  = 16,
   parameter int SLIP_WAIT  = 32
) (
   input  logic        USER_CLK,
   input  logic        SYSTEM_RESET_N,
   input  logic [1:0]  HEADER_IN,
   input  logic        HEADER_IN_VALID,
   input  logic        ERR_CLR,
   output logic        SLIP,
   output logic        WORD_LOCK,
   output logic        LOCK_LOST,
   output logic        DATA_EN,
   output logic [15:0] ERR_COUNT
);
   state_t     state;
   logic [7:0] good_cnt, win_cnt, err_cnt, wait_cnt;
   logic       good;
   assign good    = is_good_hdr(HEADER_IN);
   assign DATA_EN = HEADER_IN_VALID && WORD_LOCK;
   always_ff @(posedge USER_CLK) begin
      if (!SYSTEM_RESET_N) begin
         state     <= ST_HUNT;
         good_cnt  <= '0;
         win_cnt   <= '0;
         err_cnt   <= '0;
         wait_cnt  <= '0;
         SLIP      <= 1'b0;
         WORD_LOCK <= 1'b0;
         LOCK_LOST <= 1'b0;
      end else begin
         SLIP      <= 1'b0;
         LOCK_LOST <= 1'b0;
         case (state)
            ST_HUNT: if (HEADER_IN_VALID) begin
               if (!good) begin
                  SLIP     <= 1'b1;
                  good_cnt <= '0;
                  wait_cnt <= '0;
                  state    <= ST_WAIT;
               end else if (good_cnt + 8'd1 == 8'(LOCK_COUNT)) begin
                  WORD_LOCK <= 1'b1;
                  good_cnt  <= '0;
                  win_cnt   <= '0;
                  err_cnt   <= '0;
                  state     <= ST_LOCKED;
               end else good_cnt <= good_cnt + 8'd1;
            end
            // gearbox settle time counts raw cycles, gaps included
            ST_WAIT: if (wait_cnt + 8'd1 == 8'(SLIP_WAIT)) begin
               good_cnt <= '0;
               wait_cnt <= '0;
               state    <= ST_HUNT;
            end else wait_cnt <= wait_cnt + 8'd1;
            ST_LOCKED: if (HEADER_IN_VALID) begin
               if (!good && err_cnt + 8'd1 == 8'(ERR_LIMIT)) begin
                  WORD_LOCK <= 1'b0;
                  LOCK_LOST <= 1'b1;
                  SLIP      <= 1'b1;
                  wait_cnt  <= '0;
                  state     <= ST_WAIT;
               end else if (win_cnt + 8'd1 == 8'(WINDOW)) begin
                  win_cnt <= '0;
                  err_cnt <= '0;
               end else begin
                  win_cnt <= win_cnt + 8'd1;
                  err_cnt <= err_cnt + {7'd0, !good};
               end
            end
            default: state <= ST_HUNT;
         endcase
      end
   end
   rx_sat_counter #(.W(16)) u_err_count (
      .USER_CLK       (USER_CLK),
      .SYSTEM_RESET_N (SYSTEM_RESET_N),
      .clr            (ERR_CLR),
      .inc            (state == ST_LOCKED && HEADER_IN_VALID && !good),
      .count          (ERR_COUNT)
   );
endmodule

// File: tb/tb_rx_word_lock.sv
// tb_rx_word_lock: directed stimulus against a cycle-timestamp model of the word-lock rules
module tb_rx_word_lock;
   localparam int LC = 64, WN = 64, EL = 16, SW = 32;
   logic        USER_CLK = 1'b0;
   logic        SYSTEM_RESET_N = 1'b0;
   logic [1:0]  HEADER_IN = 2'b01;
   logic        HEADER_IN_VALID = 1'b0;
   logic        ERR_CLR = 1'b0;
   logic        SLIP, WORD_LOCK, LOCK_LOST, DATA_EN;
   logic [15:0] ERR_COUNT;
   rx_word_lock #(.LOCK_COUNT(LC), .WINDOW(WN), .ERR_LIMIT(EL), .SLIP_WAIT(SW)) dut (
      .USER_CLK        (USER_CLK),
      .SYSTEM_RESET_N  (SYSTEM_RESET_N),
      .HEADER_IN       (HEADER_IN),
      .HEADER_IN_VALID (HEADER_IN_VALID),
      .ERR_CLR         (ERR_CLR),
      .SLIP            (SLIP),
      .WORD_LOCK       (WORD_LOCK),
      .LOCK_LOST       (LOCK_LOST),
      .DATA_EN         (DATA_EN),
      .ERR_COUNT       (ERR_COUNT)
   );
   always #5 USER_CLK = ~USER_CLK;
   int checks = 0, passed = 0, slips = 0, losts = 0;
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endtask
   // model: mode 0 = hunting, 1 = ignoring headers until cycle m_resume, 2 = locked
   int m_mode, m_run, m_win, m_err, m_errc, m_resume, cyc;
   bit m_slip, m_lock, m_lost, m_ok, bad;
   always @(posedge USER_CLK) begin
      cyc++;
      m_slip = 0;
      m_lost = 0;
      bad = !(HEADER_IN == 2'b01 || HEADER_IN == 2'b10);
      if (!SYSTEM_RESET_N) begin
         m_mode = 0; m_run = 0; m_win = 0; m_err = 0; m_errc = 0; m_lock = 0; m_ok = 1;
      end else begin
         if (ERR_CLR) m_errc = 0;
         else if (m_mode == 2 && HEADER_IN_VALID && bad && m_errc < 65535) m_errc++;
         if (m_mode == 0 && HEADER_IN_VALID) begin
            if (bad) begin
               m_slip = 1; m_run = 0; m_mode = 1; m_resume = cyc + SW;
            end else begin
               m_run++;
               if (m_run == LC) begin
                  m_mode = 2; m_lock = 1; m_run = 0; m_win = 0; m_err = 0;
               end
            end
         end else if (m_mode == 1) begin
            if (cyc == m_resume) begin m_mode = 0; m_run = 0; end
         end else if (m_mode == 2 && HEADER_IN_VALID) begin
            m_win++;
            if (bad) m_err++;
            if (bad && m_err == EL) begin
               m_lock = 0; m_lost = 1; m_slip = 1; m_mode = 1; m_resume = cyc + SW;
            end else if (m_win == WN) begin
               m_win = 0; m_err = 0;
            end
         end
      end
   end
   always @(negedge USER_CLK) if (m_ok) begin
      chk("SLIP", SLIP, m_slip);
      chk("WORD_LOCK", WORD_LOCK, m_lock);
      chk("LOCK_LOST", LOCK_LOST, m_lost);
      chk("ERR_COUNT", ERR_COUNT, m_errc);
      chk("DATA_EN", DATA_EN, HEADER_IN_VALID && m_lock);
      slips += int'(SLIP);
      losts += int'(LOCK_LOST);
   end
   task automatic step(input logic [1:0] h, input logic v, input logic c = 1'b0, input logic r = 1'b1);
      HEADER_IN = h;
      HEADER_IN_VALID = v;
      ERR_CLR = c;
      SYSTEM_RESET_N = r;
      @(posedge USER_CLK);
      #1;
   endtask
   initial begin
      int k, nv;
      step(2'b01, 1'b0, 1'b0, 1'b0);
      step(2'b01, 1'b0, 1'b0, 1'b0);
      chk("rst_lock", WORD_LOCK, 0);
      chk("rst_slip", SLIP, 0);
      chk("rst_errc", ERR_COUNT, 0);
      repeat (63) step(2'b01, 1'b1);
      chk("lock_after_63", WORD_LOCK, 0);
      step(2'b01, 1'b1);
      chk("lock_after_64", WORD_LOCK, 1);
      chk("no_slip_clean_lock", slips, 0);
      step(2'b10, 1'b0);
      step(2'b10, 1'b1);
      step(2'b00, 1'b0);
      step(2'b01, 1'b1);
      step(2'b01, 1'b1, 1'b0, 1'b0);
      repeat (10) step(2'b01, 1'b1);
      step(2'b11, 1'b1);
      chk("slip_pulse", SLIP, 1);
      step(2'b00, 1'b1);
      chk("slip_one_cycle", SLIP, 0);
      for (int i = 0; i < 31; i++) step(i % 2 == 0 ? 2'b11 : 2'b00, 1'b1);
      chk("slips_during_wait", slips, 1);
      repeat (63) step(2'b10, 1'b1);
      chk("relock_after_63", WORD_LOCK, 0);
      step(2'b01, 1'b1);
      chk("relock_after_64", WORD_LOCK, 1);
      for (int w = 0; w < 4; w++)
         for (int i = 0; i < 64; i++) step((i % 4 == 0 && i < 60) ? 2'b11 : 2'b01, 1'b1);
      chk("errc_4_windows", ERR_COUNT, 60);
      chk("lock_4_windows", WORD_LOCK, 1);
      chk("no_lost_4_windows", losts, 0);
      step(2'b01, 1'b1, 1'b1);
      chk("errc_cleared", ERR_COUNT, 0);
      repeat (15) step(2'b00, 1'b1);
      chk("lock_after_15_bad", WORD_LOCK, 1);
      step(2'b11, 1'b1);
      chk("lock_lost_wl", WORD_LOCK, 0);
      chk("lock_lost_pulse", LOCK_LOST, 1);
      chk("lock_lost_slip", SLIP, 1);
      chk("lock_lost_errc", ERR_COUNT, 16);
      step(2'b01, 1'b1);
      chk("lock_lost_one_cycle", LOCK_LOST, 0);
      step(2'b01, 1'b1, 1'b0, 1'b0);
      k = 0;
      nv = 0;
      while (nv < 63) begin
         if (k % 33 == 32) step(2'b11, 1'b0);
         else begin step(2'b01, 1'b1); nv++; end
         k++;
      end
      chk("gap_lock_after_63", WORD_LOCK, 0);
      if (k % 33 == 32) step(2'b11, 1'b0);
      step(2'b01, 1'b1);
      chk("gap_lock_after_64", WORD_LOCK, 1);
      step(2'b11, 1'b1, 1'b1);
      chk("clr_beats_bad", ERR_COUNT, 0);
      repeat (5) step(2'b00, 1'b1);
      chk("errc_5", ERR_COUNT, 5);
      step(2'b01, 1'b1, 1'b0, 1'b0);
      chk("rst_locked_wl", WORD_LOCK, 0);
      chk("rst_locked_errc", ERR_COUNT, 0);
      chk("rst_locked_lost", LOCK_LOST, 0);
      chk("rst_locked_slip", SLIP, 0);
      repeat (64) step(2'b10, 1'b1);
      chk("lock_after_rst", WORD_LOCK, 1);
      step(2'b01, 1'b0);
      step(2'b01, 1'b0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
